// File: rtl/regfile_pkg.sv
// Shared constants, index type and dump FSM states for the register-file dump reader.
package regfile_pkg;
  localparam int REG_WIDTH = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [1:0] {IDLE, READ, HOLD, FIN} dump_state_t;
endpackage

// File: rtl/dump_out_stage.sv
// Output register stage for the dump reader: captured word, index, valid flag and handshake fire.
// With REGFILE_DUMP_CHECKSUM_EN defined it also keeps a running mod-2^WIDTH sum of transferred words.
module dump_out_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             capture,
  input  logic             abort,
  input  logic             ready,
`ifdef REGFILE_DUMP_CHECKSUM_EN
  input  logic             clear_sum,
  output logic [WIDTH-1:0] checksum,
`endif
  input  logic [WIDTH-1:0] rd_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_idx,
  output logic             out_valid,
  output logic             fire
);
  logic [WIDTH-1:0] data_reg;
  logic [AW-1:0]    idx_reg;
  logic             valid_reg;

  // An abort wins over a handshake seen in the same cycle.
  assign fire = valid_reg & ready & ~abort;

  always_ff @(posedge clk) begin
    if (!clr) begin
      data_reg  <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (capture) begin
        data_reg <= rd_data;
        idx_reg  <= rd_addr;
      end
      if (abort)        valid_reg <= 1'b0;
      else if (capture) valid_reg <= 1'b1;
      else if (fire)    valid_reg <= 1'b0;
    end
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0] sum_reg;

  always_ff @(posedge clk) begin
    if (!clr)           sum_reg <= '0;
    else if (clear_sum) sum_reg <= '0;
    else if (fire)      sum_reg <= sum_reg + data_reg;
  end

  assign checksum = sum_reg;
`endif

  assign out_data  = data_reg;
  assign out_idx   = idx_reg;
  assign out_valid = valid_reg;
endmodule

// File: rtl/regfile_dump_reader.sv
// Walks registers First..Last through one read port and streams them out over valid/ready.
// Optional running checksum output enabled by defining REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int NREG  = REG_COUNT,
  parameter int AW    = REG_AW
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Start,
  input  logic [AW-1:0]    First,
  input  logic [AW-1:0]    Last,
  input  logic             Abort,
  output logic [AW-1:0]    Rd_addr,
  input  logic [WIDTH-1:0] Rd_data,
  output logic [WIDTH-1:0] Out_data,
  output logic [AW-1:0]    Out_idx,
  output logic             Out_valid,
  input  logic             Out_ready,
`ifdef REGFILE_DUMP_CHECKSUM_EN
  output logic [WIDTH-1:0] Checksum,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             Err
);
  dump_state_t   state_reg, state_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_next;
  logic [AW-1:0] last_reg, last_next;
  logic          busy_reg, done_reg, err_reg;
  logic          err_next;
  logic          capture, start_accept, abort_active, fire;

  assign abort_active = Abort & (state_reg != IDLE);

  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    last_next    = last_reg;
    capture      = 1'b0;
    start_accept = 1'b0;
    err_next     = 1'b0;
    if (abort_active) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            if (First <= Last) begin
              start_accept = 1'b1;
              last_next    = Last;
              rd_addr_next = First;
              state_next   = READ;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        READ: begin
          capture    = 1'b1;
          state_next = HOLD;
        end
        HOLD: begin
          // Compare before incrementing so a dump ending at the top register never wraps.
          if (fire) begin
            if (Out_idx == last_reg) begin
              state_next = FIN;
            end else begin
              if (rd_addr_reg != AW'(NREG - 1)) rd_addr_next = rd_addr_reg + AW'(1);
              state_next = READ;
            end
          end
        end
        FIN:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_reg   <= IDLE;
      rd_addr_reg <= '0;
      last_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_addr_reg <= rd_addr_next;
      last_reg    <= last_next;
      busy_reg    <= (state_next != IDLE);
      done_reg    <= (state_next == FIN);
      err_reg     <= err_next;
    end
  end

  dump_out_stage #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_out (
    .clk      (Clk),
    .clr      (Clr),
    .capture  (capture),
    .abort    (abort_active),
    .ready    (Out_ready),
`ifdef REGFILE_DUMP_CHECKSUM_EN
    .clear_sum(start_accept),
    .checksum (Checksum),
`endif
    .rd_data  (Rd_data),
    .rd_addr  (rd_addr_reg),
    .out_data (Out_data),
    .out_idx  (Out_idx),
    .out_valid(Out_valid),
    .fire     (fire)
  );

  assign Rd_addr = rd_addr_reg;
  assign Busy    = busy_reg;
  assign Done    = done_reg;
  assign Err     = err_reg;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: stimulus pushes expected words, a monitor pops on handshakes.
module tb_regfile_dump_reader;
  logic        Clk = 1'b0;
  logic        Clr, Start, Abort, Out_ready;
  logic [4:0]  First, Last, Rd_addr, Out_idx;
  logic [31:0] Rd_data, Out_data;
  logic        Out_valid, Busy, Done, Err;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [31:0] Checksum;
`endif

  logic [31:0] regs [32];
  assign Rd_data = (Rd_addr == 5'd0) ? 32'd0 : regs[Rd_addr];

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  regfile_dump_reader dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .First(First), .Last(Last), .Abort(Abort),
    .Rd_addr(Rd_addr), .Rd_data(Rd_data), .Out_data(Out_data), .Out_idx(Out_idx),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
`ifdef REGFILE_DUMP_CHECKSUM_EN
    .Checksum(Checksum),
`endif
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [4:0] idx, input logic [31:0] data);
    exp_t e;
    e.idx = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Waits for the Done pulse; reports ticks taken and whether Rd_addr hit 0 on the way.
  task automatic wait_done(output int cyc, output logic saw_zero);
    cyc = 0;
    saw_zero = 1'b0;
    while (!Done && cyc < 100) begin
      tick();
      cyc++;
      if (Rd_addr == 5'd0) saw_zero = 1'b1;
    end
    check("done_seen", {31'd0, Done}, 32'd1);
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge Clk) begin
    if (Clr === 1'b1 && Out_valid === 1'b1 && Out_ready === 1'b1 && Abort === 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got idx=%0d data=%h, expected no transfer", Out_idx, Out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("word_idx_%0d", e.idx), {27'd0, Out_idx}, {27'd0, e.idx});
        check($sformatf("word_data_%0d", e.idx), Out_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic saw_zero;
    logic found;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    Clr = 1'b0; Start = 1'b1; Abort = 1'b0; Out_ready = 1'b0; First = 5'd0; Last = 5'd2;

    // Reset with Start held high
    tick(); tick();
    check("rst_valid", {31'd0, Out_valid}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done_err", {30'd0, Done, Err}, 32'd0);
    check("rst_rd_addr", {27'd0, Rd_addr}, 32'd0);
    check("rst_out_data", Out_data, 32'd0);
    check("rst_out_idx", {27'd0, Out_idx}, 32'd0);
    Start = 1'b0; Clr = 1'b1;
    tick();
    check("rst_start_ignored", {31'd0, Busy}, 32'd0);

    // Full dump 0..2
    regs[1] = 32'hDEADBEEF; regs[2] = 32'hCAFEBABE;
    push(5'd0, 32'h0); push(5'd1, 32'hDEADBEEF); push(5'd2, 32'hCAFEBABE);
    Out_ready = 1'b1; First = 5'd0; Last = 5'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("full_busy", {31'd0, Busy}, 32'd1);
    check("full_rd_addr", {27'd0, Rd_addr}, 32'd0);
    wait_done(cyc, saw_zero);
    check("full_done_latency", cyc + 1, 32'd7);
    check("full_busy_at_done", {31'd0, Busy}, 32'd1);
    tick();
    check("full_after_done", {30'd0, Busy, Done}, 32'd0);
    check("full_queue_empty", exp_q.size(), 32'd0);

    // Backpressure on a single word, with a register write during the stall
    regs[5] = 32'h12345678;
    push(5'd5, 32'h12345678);
    Out_ready = 1'b0; First = 5'd5; Last = 5'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) regs[5] = 32'hA5A5A5A5;
      check("bp_valid_held", {31'd0, Out_valid}, 32'd1);
      check("bp_data_held", Out_data, 32'h12345678);
      tick();
    end
    Out_ready = 1'b1;
    tick();
    check("bp_done", {31'd0, Done}, 32'd1);
    check("bp_valid_cleared", {31'd0, Out_valid}, 32'd0);
    tick();
    check("bp_queue_empty", exp_q.size(), 32'd0);

    // Top boundary 30..31, Start together with Abort in IDLE
    regs[30] = 32'h3030_3030; regs[31] = 32'h3131_3131;
    push(5'd30, 32'h3030_3030); push(5'd31, 32'h3131_3131);
    First = 5'd30; Last = 5'd31; Start = 1'b1; Abort = 1'b1;
    tick();
    Start = 1'b0; Abort = 1'b0;
    check("top_start_with_abort", {31'd0, Busy}, 32'd1);
    wait_done(cyc, saw_zero);
    check("top_no_wrap", {31'd0, saw_zero}, 32'd0);
    check("top_rd_addr_end", {27'd0, Rd_addr}, 32'd31);
    tick();
    check("top_queue_empty", exp_q.size(), 32'd0);

    // Reversed range -> Err pulse only
    First = 5'd7; Last = 5'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("err_pulse", {31'd0, Err}, 32'd1);
    check("err_busy", {31'd0, Busy}, 32'd0);
    check("err_valid", {31'd0, Out_valid}, 32'd0);
    tick();
    check("err_one_cycle", {31'd0, Err}, 32'd0);

    // Abort in HOLD on index 4 of a 0..31 dump, with Out_ready high
    for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    push(5'd0, 32'h0);
    for (int i = 1; i < 4; i++) push(5'(i), 32'h1000_0000 + i);
    First = 5'd0; Last = 5'd31; Out_ready = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (Out_valid && Out_idx == 5'd4) found = 1'b1;
      else tick();
    end
    check("abort_reached_idx4", {31'd0, found}, 32'd1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_idle", {31'd0, Busy}, 32'd0);
    check("abort_valid", {31'd0, Out_valid}, 32'd0);
    check("abort_no_done", {31'd0, Done}, 32'd0);
    check("abort_queue_empty", exp_q.size(), 32'd0);
    tick();
    check("abort_no_late_done", {31'd0, Done}, 32'd0);

    // Restart right away, then reset mid-dump
    Out_ready = 1'b0; First = 5'd9; Last = 5'd9; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("restart_busy", {31'd0, Busy}, 32'd1);
    tick();
    check("restart_valid", {31'd0, Out_valid}, 32'd1);
    Clr = 1'b0;
    tick();
    Clr = 1'b1;
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    check("midrst_valid", {31'd0, Out_valid}, 32'd0);
    check("midrst_rd_addr", {27'd0, Rd_addr}, 32'd0);
    tick();

`ifdef REGFILE_DUMP_CHECKSUM_EN
    regs[1] = 32'h0000_0001; regs[2] = 32'hFFFF_FFFF;
    push(5'd1, 32'h1);
    Out_ready = 1'b1; First = 5'd1; Last = 5'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(cyc, saw_zero);
    tick(); tick();
    check("cks_held", Checksum, 32'h1);
    push(5'd1, 32'h1); push(5'd2, 32'hFFFF_FFFF);
    First = 5'd1; Last = 5'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("cks_cleared", Checksum, 32'h0);
    tick(); tick();
    check("cks_partial", Checksum, 32'h1);
    tick(); tick();
    check("cks_done", {31'd0, Done}, 32'd1);
    check("cks_wrap", Checksum, 32'h0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
